adc_spi_responder: RTL and testbench

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_spi_responder.sv | 190 +++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// Behavioural SPI ADC responder: synchronizes CONVST/SCLK/SDI onto CLOCK_50, simulates a
// conversion delay, then shifts out a 12-bit result while shifting in the next 6-bit config.
//
// state    | meaning
// IDLE     | waiting for a CONVST rising edge
// CONVERT  | conversion timer running; SCLK activity here is a protocol error
// WAIT_LOW | conversion done, waiting for CONVST to return low
// SHIFT    | result out on SDO, config in on SDI
module adc_spi_responder #(
  parameter int CONV_CYCLES = 80,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        ADC_CONVST,
  input  logic        ADC_SCLK,
  input  logic        ADC_SDI,
  input  logic [95:0] sample_data,
  output logic        ADC_SDO,
  output logic [5:0]  cfg_word,
  output logic        busy,
  output logic        frame_done,
  output logic        protocol_err
);

  localparam int CW = ($clog2(CONV_CYCLES) < 1) ? 1 : $clog2(CONV_CYCLES);
  localparam logic [CW-1:0] CONV_LOAD = CW'(CONV_CYCLES - 1);
  localparam logic [5:0] CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {IDLE, CONVERT, WAIT_LOW, SHIFT} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] convst_sync_q, sclk_sync_q, sdi_sync_q;
  logic convst_prev_q, sclk_prev_q;
  logic [CW-1:0] conv_cnt_q, conv_cnt_d;
  logic [11:0] result_q, result_d;
  logic [11:0] out_sh_q, out_sh_d;
  logic sdo_q, sdo_d;
  logic [5:0] cfg_sh_q, cfg_sh_d;
  logic [5:0] cfg_q, cfg_d;
  logic [3:0] rise_cnt_q, rise_cnt_d;
  logic [3:0] fall_cnt_q, fall_cnt_d;
  logic done_q, done_d;
  logic perr_q, perr_d;

  logic convst_s, sclk_s, sdi_s;
  logic convst_rise, sclk_rise, sclk_fall;
  logic start_conv, enter_shift;
  logic [2:0] ch_sel;
  logic [6:0] ch_base;
  logic [11:0] sel_word;

  assign convst_s    = convst_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
  assign convst_rise = convst_s & ~convst_prev_q;
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;

  // Channel index ordering is {S1, S0, O/S}; differential mode returns zero.
  assign ch_sel   = {cfg_q[3], cfg_q[2], cfg_q[4]};
  assign ch_base  = 7'(ch_sel) * 7'd12;
  assign sel_word = cfg_q[5] ? sample_data[ch_base +: 12] : 12'h000;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      convst_sync_q <= '0;
      sclk_sync_q   <= '0;
      sdi_sync_q    <= '0;
      convst_prev_q <= 1'b0;
      sclk_prev_q   <= 1'b0;
    end else begin
      convst_sync_q[0] <= ADC_CONVST;
      sclk_sync_q[0]   <= ADC_SCLK;
      sdi_sync_q[0]    <= ADC_SDI;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        convst_sync_q[i] <= convst_sync_q[i-1];
        sclk_sync_q[i]   <= sclk_sync_q[i-1];
        sdi_sync_q[i]    <= sdi_sync_q[i-1];
      end
      convst_prev_q <= convst_s;
      sclk_prev_q   <= sclk_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    conv_cnt_d  = conv_cnt_q;
    result_d    = result_q;
    out_sh_d    = out_sh_q;
    sdo_d       = sdo_q;
    cfg_sh_d    = cfg_sh_q;
    cfg_d       = cfg_q;
    rise_cnt_d  = rise_cnt_q;
    fall_cnt_d  = fall_cnt_q;
    done_d      = 1'b0;
    perr_d      = perr_q;
    start_conv  = 1'b0;
    enter_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (convst_rise) start_conv = 1'b1;
      end
      CONVERT: begin
        if (sclk_rise) perr_d = 1'b1;
        if (conv_cnt_q == '0) begin
          if (!convst_s) enter_shift = 1'b1;
          else           state_d = WAIT_LOW;
        end else begin
          conv_cnt_d = conv_cnt_q - 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!convst_s) enter_shift = 1'b1;
      end
      SHIFT: begin
        if (convst_rise) begin
          start_conv = 1'b1;
        end else if (sclk_rise) begin
          if (rise_cnt_q < 4'd6) cfg_sh_d = {cfg_sh_q[4:0], sdi_s};
          if (rise_cnt_q != 4'hF) rise_cnt_d = rise_cnt_q + 1'b1;
        end else if (sclk_fall) begin
          if (fall_cnt_q == 4'd11) begin
            done_d  = 1'b1;
            sdo_d   = 1'b0;
            state_d = IDLE;
            if (rise_cnt_q >= 4'd6) cfg_d = cfg_sh_q;
          end else begin
            sdo_d      = out_sh_q[11];
            out_sh_d   = {out_sh_q[10:0], 1'b0};
            fall_cnt_d = fall_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_conv) begin
      state_d    = CONVERT;
      conv_cnt_d = CONV_LOAD;
      result_d   = sel_word;
      sdo_d      = 1'b0;
    end
    // SDO presents the MSB as soon as SHIFT is entered, before any SCLK edge.
    if (enter_shift) begin
      state_d    = SHIFT;
      sdo_d      = result_q[11];
      out_sh_d   = {result_q[10:0], 1'b0};
      rise_cnt_d = '0;
      fall_cnt_d = '0;
      cfg_sh_d   = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      conv_cnt_q <= '0;
      result_q   <= '0;
      out_sh_q   <= '0;
      sdo_q      <= 1'b0;
      cfg_sh_q   <= '0;
      cfg_q      <= CFG_RESET;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      result_q   <= result_d;
      out_sh_q   <= out_sh_d;
      sdo_q      <= sdo_d;
      cfg_sh_q   <= cfg_sh_d;
      cfg_q      <= cfg_d;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
    end
  end

  assign ADC_SDO      = sdo_q;
  assign cfg_word     = cfg_q;
  assign busy         = (state_q == CONVERT);
  assign frame_done   = done_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: table-driven frames, hand-written corner sequences and
// randomized frames checked against a channel-select model of the ADC.
module tb_adc_spi_responder;

  localparam int CONV = 80;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n, convst, sclk, sdi;
  logic [95:0] sample_data;
  logic sdo, busy, frame_done, perr;
  logic [5:0] cfg_word;

  int checks = 0;
  int errors = 0;
  int fd_total = 0;

  adc_spi_responder #(.CONV_CYCLES(CONV), .SYNC_STAGES(2)) dut (
    .CLOCK_50    (clk),
    .RESET_N     (rst_n),
    .ADC_CONVST  (convst),
    .ADC_SCLK    (sclk),
    .ADC_SDI     (sdi),
    .sample_data (sample_data),
    .ADC_SDO     (sdo),
    .cfg_word    (cfg_word),
    .busy        (busy),
    .frame_done  (frame_done),
    .protocol_err(perr)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) fd_total <= fd_total + 1;

  typedef struct {
    logic [5:0]  cfg_in;
    logic [11:0] exp_sdo;
    logic [5:0]  exp_cfg;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: pick a channel by arithmetic on the config fields.
  function automatic logic [11:0] model_result(input logic [95:0] sd, input logic [5:0] cfg);
    int ch;
    if (cfg[5] == 1'b0) return 12'h000;
    ch = 4 * int'(cfg[3]) + 2 * int'(cfg[2]) + int'(cfg[4]);
    return sd[ch*12 +: 12];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; convst = 1'b0; sclk = 1'b0; sdi = 1'b0;
    clk_n(3);
    rst_n = 1'b1;
    clk_n(2);
  endtask

  task automatic pulse_convst();
    convst = 1'b1;
    clk_n(4);
    convst = 1'b0;
  endtask

  task automatic wait_conv();
    int t = 0;
    while (busy !== 1'b1 && t < 20) begin clk_n(1); t++; end
    while (busy === 1'b1 && t < 300) begin clk_n(1); t++; end
    if (t >= 300 || busy !== 1'b0) check("conv_timeout", 32'(t), 32'(CONV));
    clk_n(2);
  endtask

  task automatic run_frame(input logic [5:0] cfg_in, input int n, input bit scramble,
                           output logic [11:0] word);
    word = '0;
    for (int i = 0; i < n; i++) begin
      sdi = (i < 6) ? cfg_in[5-i] : 1'($urandom);
      clk_n(HALF);
      word = {word[10:0], sdo};
      sclk = 1'b1;
      if (scramble && i == 3) sample_data = {$urandom, $urandom, $urandom};
      clk_n(HALF);
      sclk = 1'b0;
    end
    clk_n(HALF);
  endtask

  initial begin
    logic [11:0] w;
    logic [5:0] cfg_m, c;
    logic [95:0] snap;
    int fd0, busy_cnt, c_i;

    tbl[0] = '{6'b110010, 12'hA5C, 6'b110010};
    tbl[1] = '{6'b101000, 12'h3F1, 6'b101000};
    tbl[2] = '{6'b111110, 12'h789, 6'b111110};
    tbl[3] = '{6'b000010, 12'hF0F, 6'b000010};
    tbl[4] = '{6'b100110, 12'h000, 6'b100110};
    tbl[5] = '{6'b110100, 12'h123, 6'b110100};
    tbl[6] = '{6'b100010, 12'h456, 6'b100010};

    sample_data = {12'hF0F, 12'hDEF, 12'hABC, 12'h789, 12'h456, 12'h123, 12'h3F1, 12'hA5C};
    do_reset();
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_cfg", 32'(cfg_word), 32'b100010);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);

    for (int k = 0; k < 7; k++) begin
      fd0 = fd_total;
      pulse_convst();
      wait_conv();
      run_frame(tbl[k].cfg_in, 12, 1'b0, w);
      check($sformatf("tbl%0d_sdo", k), 32'(w), 32'(tbl[k].exp_sdo));
      check($sformatf("tbl%0d_done", k), 32'(fd_total - fd0), 32'd1);
      check($sformatf("tbl%0d_cfg", k), 32'(cfg_word), 32'(tbl[k].exp_cfg));
    end

    // Abort after 5 SCLKs; the new frame must reflect the sample present at re-pulse.
    fd0 = fd_total;
    pulse_convst();
    wait_conv();
    run_frame(6'b111111, 5, 1'b0, w);
    sample_data[11:0] = 12'h6B7;
    pulse_convst();
    check("abort_done", 32'(fd_total - fd0), 32'd0);
    check("abort_cfg", 32'(cfg_word), 32'b100010);
    wait_conv();
    run_frame(6'b100010, 12, 1'b0, w);
    check("abort_sdo", 32'(w), 32'h6B7);
    check("abort_done2", 32'(fd_total - fd0), 32'd1);

    // Reset at the 7th SCLK rising edge.
    fd0 = fd_total;
    pulse_convst();
    wait_conv();
    run_frame(6'b101010, 6, 1'b0, w);
    sclk = 1'b1;
    clk_n(2);
    rst_n = 1'b0;
    clk_n(2);
    check("midrst_sdo", 32'(sdo), 32'd0);
    check("midrst_cfg", 32'(cfg_word), 32'b100010);
    sclk = 1'b0;
    clk_n(2);
    rst_n = 1'b1;
    clk_n(3);
    check("midrst_done", 32'(fd_total - fd0), 32'd0);
    pulse_convst();
    wait_conv();
    run_frame(6'b110010, 12, 1'b0, w);
    check("midrst_sdo2", 32'(w), 32'h6B7);
    check("midrst_done2", 32'(fd_total - fd0), 32'd1);
    check("midrst_cfg2", 32'(cfg_word), 32'b110010);

    // SCLK during conversion, plus an ignored CONVST re-pulse.
    do_reset();
    sample_data[11:0] = 12'hA5C;
    busy_cnt = 0;
    convst = 1'b1;
    c_i = 0;
    while (c_i < 300) begin
      clk_n(1);
      c_i++;
      if (busy === 1'b1) busy_cnt++;
      if (c_i == 4)  convst = 1'b0;
      if (c_i == 20) sclk = 1'b1;
      if (c_i == 24) sclk = 1'b0;
      if (c_i == 28) sclk = 1'b1;
      if (c_i == 32) sclk = 1'b0;
      if (c_i == 40) convst = 1'b1;
      if (c_i == 44) convst = 1'b0;
      if (c_i == 36) begin
        check("conv_perr", 32'(perr), 32'd1);
        check("conv_busy", 32'(busy), 32'd1);
      end
      if (busy_cnt > 0 && busy !== 1'b1) break;
    end
    check("conv_busy_len", 32'(busy_cnt), 32'(CONV));
    clk_n(2);
    run_frame(6'b100010, 12, 1'b0, w);
    check("conv_frame_sdo", 32'(w), 32'hA5C);
    check("perr_sticky", 32'(perr), 32'd1);
    do_reset();
    check("perr_cleared", 32'(perr), 32'd0);

    // Randomized frames with sample_data disturbed mid-frame.
    cfg_m = 6'b100010;
    for (int k = 0; k < 25; k++) begin
      sample_data = {$urandom, $urandom, $urandom};
      snap = sample_data;
      c = 6'($urandom);
      fd0 = fd_total;
      pulse_convst();
      wait_conv();
      run_frame(c, 12, 1'b1, w);
      check($sformatf("rnd%0d_sdo", k), 32'(w), 32'(model_result(snap, cfg_m)));
      check($sformatf("rnd%0d_done", k), 32'(fd_total - fd0), 32'd1);
      cfg_m = c;
      check($sformatf("rnd%0d_cfg", k), 32'(cfg_word), 32'(cfg_m));
      check($sformatf("rnd%0d_sdo_idle", k), 32'(sdo), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
